reaction_game_ctrl: RTL and testbench



---
 rtl/reaction_pkg.sv | 28 ++
 rtl/ms_tick_gen.sv | 32 +++
 rtl/reaction_game_ctrl.sv | 174 +++++++++++++++++
 tb/tb_reaction_game_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction-time game controller.
// Holds the sequencer state encoding, LFSR seed/taps and the
// millisecond counter width used by the top level and its helpers.
package reaction_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    WAIT = 3'd2,
    GO   = 3'd3,
    DONE = 3'd4,
    FOUL = 3'd5
  } state_t;

  // 3-bit maximal-length LFSR: shift left, feedback = q[2] ^ q[1].
  // Sequence from the seed: 001,010,101,011,111,110,100 (period 7, never 000).
  localparam logic [2:0] LFSR_SEED   = 3'b001;
  localparam int         LFSR_TAP_HI = 2;
  localparam int         LFSR_TAP_LO = 1;

  // Width of the reaction counter and result bus.
  localparam int MS_W = 10;

  function automatic logic [2:0] lfsr_next(input logic [2:0] q);
    return {q[1:0], q[LFSR_TAP_HI] ^ q[LFSR_TAP_LO]};
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond tick prescaler.
// Ports: clk/rst (sync, active-high), clr forces the count back to 0,
//        tick is high for one cycle every TICK_DIV cycles (count == TICK_DIV-1).
module ms_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // tick is taken from the count itself, so it stays valid in the cycle
  // where clr is raised; the caller relies on that for the final WAIT tick.
  assign tick = (cnt == LAST);

endmodule

// File: rtl/reaction_game_ctrl.sv
// Reaction-time game sequencer: random wait, GO stimulus, ms reaction
// measurement with saturation/timeout, and early-press (foul) detection.
// Ports: clk, rst (sync, active-high); start_btn/react_btn debounced levels;
//        lfsr_sel/sel_valid -> delay-pattern decoder; led_go, result_ms,
//        result_valid, timeout, foul, busy -> display/LED datapath.
module reaction_game_ctrl
  import reaction_pkg::*;
#(
  parameter int TICK_DIV      = 50000,
  parameter int DELAY_UNIT_MS = 500,
  parameter int MAX_MS        = 999
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_btn,
  input  logic            react_btn,
  output logic [2:0]      lfsr_sel,
  output logic            sel_valid,
  output logic            led_go,
  output logic [MS_W-1:0] result_ms,
  output logic            result_valid,
  output logic            timeout,
  output logic            foul,
  output logic            busy
);

  // Largest wait is 8 delay steps (lfsr_sel = 7).
  localparam int WAIT_MAX = 8 * DELAY_UNIT_MS;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

  localparam logic [MS_W-1:0]   MS_MAX    = MS_W'(MAX_MS);
  localparam logic [MS_W-1:0]   MS_LAST   = MS_W'(MAX_MS - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  if (MAX_MS < 1 || MAX_MS > (1 << MS_W) - 1) begin : g_bad_max
    $error("MAX_MS must be in 1..1023");
  end

  state_t state, state_nxt;

  logic [2:0]        lfsr_q;
  logic              start_q, react_q;
  logic              start_rise, react_rise;
  logic [WAIT_W-1:0] wait_cnt;
  logic [MS_W-1:0]   ms_cnt;
  logic              tick, tick_clr;

  // Single-cycle controls from the next-state logic to the datapath.
  logic              accept_start;
  logic              capture_react;
  logic              saturate;
  logic              early_press;
  logic              enter_go;

  assign start_rise = start_btn & ~start_q;
  assign react_rise = react_btn & ~react_q;

  ms_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .tick (tick)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    tick_clr      = 1'b0;
    accept_start  = 1'b0;
    capture_react = 1'b0;
    saturate      = 1'b0;
    early_press   = 1'b0;
    enter_go      = 1'b0;
    case (state)
      // DONE and FOUL behave like IDLE: a new start goes straight to ARM.
      IDLE, DONE, FOUL: begin
        if (start_rise) begin
          state_nxt    = ARM;
          accept_start = 1'b1;
        end
      end
      ARM: begin
        state_nxt = WAIT;
        tick_clr  = 1'b1;
      end
      WAIT: begin
        // An early press wins over a wait that expires in the same cycle.
        if (react_rise) begin
          state_nxt   = FOUL;
          early_press = 1'b1;
        end else if (tick && wait_cnt == WAIT_ONE) begin
          state_nxt = GO;
          tick_clr  = 1'b1;
          enter_go  = 1'b1;
        end
      end
      GO: begin
        // A press on a tick cycle captures the count before that tick.
        if (react_rise) begin
          state_nxt     = DONE;
          capture_react = 1'b1;
        end else if (tick && ms_cnt == MS_LAST) begin
          state_nxt = DONE;
          saturate  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q    <= LFSR_SEED;
      start_q   <= 1'b1;   // a button held through reset must not fire
      react_q   <= 1'b1;
      lfsr_sel  <= '0;
      sel_valid <= 1'b0;
      wait_cnt  <= '0;
      ms_cnt    <= '0;
      result_ms <= '0;
      timeout   <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_next(lfsr_q);
      start_q <= start_btn;
      react_q <= react_btn;

      if (accept_start) begin
        lfsr_sel  <= lfsr_q;
        sel_valid <= 1'b1;
        timeout   <= 1'b0;
      end

      // lfsr_sel was captured on the way into ARM, so it is stable here.
      if (state == ARM) begin
        wait_cnt <= WAIT_W'((int'(lfsr_sel) + 1) * DELAY_UNIT_MS);
      end else if (state == WAIT && tick && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - WAIT_ONE;
      end

      if (enter_go) begin
        ms_cnt <= '0;
      end else if (state == GO && tick && ms_cnt != MS_MAX) begin
        ms_cnt <= ms_cnt + MS_W'(1);
      end

      if (capture_react) begin
        result_ms <= ms_cnt;
      end else if (saturate) begin
        result_ms <= MS_MAX;
        timeout   <= 1'b1;
      end else if (early_press) begin
        result_ms <= '0;
      end
    end
  end

  // ------------------------------------------------------------ outputs
  assign led_go       = (state == GO);
  assign busy         = (state == ARM) || (state == WAIT) || (state == GO);
  assign result_valid = (state == DONE);
  assign foul         = (state == FOUL);

endmodule

// File: tb/tb_reaction_game_ctrl.sv
// Bench for reaction_game_ctrl: directed scenarios plus random button traffic,
// checked every cycle against a timestamp-based model of a game round.
module tb_reaction_game_ctrl;

  localparam int TD = 4;    // cycles per ms tick
  localparam int DU = 2;    // ms per delay step
  localparam int MX = 20;   // saturation / timeout value

  localparam logic [2:0] SEQ [7] = '{3'd1, 3'd2, 3'd5, 3'd3, 3'd7, 3'd6, 3'd4};

  logic       clk = 1'b0;
  logic       rst, start_btn, react_btn;
  logic [2:0] lfsr_sel;
  logic       sel_valid, led_go, result_valid, timeout, foul, busy;
  logic [9:0] result_ms;
  logic [18:0] got_outs;

  reaction_game_ctrl #(
    .TICK_DIV      (TD),
    .DELAY_UNIT_MS (DU),
    .MAX_MS        (MX)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_btn    (start_btn),
    .react_btn    (react_btn),
    .lfsr_sel     (lfsr_sel),
    .sel_valid    (sel_valid),
    .led_go       (led_go),
    .result_ms    (result_ms),
    .result_valid (result_valid),
    .timeout      (timeout),
    .foul         (foul),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  assign got_outs = {lfsr_sel, sel_valid, led_go, result_ms, result_valid, timeout, foul, busy};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_t: clock cycles since the last reset edge (LFSR value = SEQ[m_t % 7]).
  // A round started at cycle m_s: ARM at m_s+1, WAIT for W cycles, then GO.
  int         m_t, m_s, m_mode, m_res;   // mode: 0 idle, 1 round, 2 done, 3 foul
  logic [2:0] m_sel;
  bit         m_selv, m_tmo, m_sq, m_rq;

  function automatic int wait_len();
    return (int'(m_sel) + 1) * DU * TD;
  endfunction

  task automatic model_edge(input bit r, input bit sb, input bit rb);
    int c, d, w, i;
    bit sr, rr;
    if (r) begin
      m_t = 0; m_s = 0; m_mode = 0; m_res = 0;
      m_sel = 3'd0; m_selv = 0; m_tmo = 0; m_sq = 1; m_rq = 1;
      return;
    end
    c  = m_t;
    sr = sb && !m_sq;
    rr = rb && !m_rq;
    w  = wait_len();
    d  = c - m_s;
    if (m_mode != 1) begin
      if (sr) begin
        m_sel = SEQ[c % 7]; m_selv = 1; m_tmo = 0; m_mode = 1; m_s = c;
      end
    end else if (d >= 2 && d <= 1 + w) begin
      if (rr) begin m_mode = 3; m_res = 0; end
    end else if (d >= 2 + w) begin
      i = d - 2 - w;
      if (rr) begin
        m_res = i / TD; m_mode = 2;
      end else if (i == MX * TD - 1) begin
        m_res = MX; m_tmo = 1; m_mode = 2;
      end
    end
    m_sq = sb;
    m_rq = rb;
    m_t++;
  endtask

  function automatic logic [18:0] exp_outs();
    logic go;
    go = (m_mode == 1) && ((m_t - m_s) >= 2 + wait_len());
    return {m_sel, m_selv, go, 10'(m_res), (m_mode == 2), m_tmo, (m_mode == 3), (m_mode == 1)};
  endfunction

  task automatic step(input bit r, input bit sb, input bit rb);
    rst = r; start_btn = sb; react_btn = rb;
    @(posedge clk);
    model_edge(r, sb, rb);
    #1;
    check_val("outs", 32'(got_outs), 32'(exp_outs()));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    logic [7:0] mask;
    bit sb, rb, rr;

    rst = 1'b1; start_btn = 1'b0; react_btn = 1'b0;
    repeat (3) step(1, 0, 0);
    check_val("reset_outs", 32'(got_outs), 32'd0);

    // First round at LFSR phase 001: ARM + 16 WAIT cycles, react after 3 ticks.
    do step(0, 0, 0); while (m_t % 7 != 0);
    step(0, 1, 0);
    check_val("sel_first", 32'(lfsr_sel), 32'd1);
    check_val("busy_first", 32'(busy), 32'd1);
    cnt = 0;
    while (!led_go && cnt < 300) begin step(0, 1, 0); cnt++; end
    check_val("arm_wait_len", cnt, 32'd17);
    repeat (13) step(0, 1, 0);
    step(0, 1, 1);
    check_val("react_ms", 32'(result_ms), 32'd3);
    check_val("react_valid", 32'(result_valid), 32'd1);
    check_val("react_led", 32'(led_go), 32'd0);
    check_val("react_tmo", 32'(timeout), 32'd0);

    // Early press during WAIT.
    step(0, 0, 0);
    step(0, 1, 0);
    repeat (6) step(0, 1, 0);
    step(0, 1, 1);
    check_val("foul_flag", 32'(foul), 32'd1);
    check_val("foul_ms", 32'(result_ms), 32'd0);
    check_val("foul_led", 32'(led_go), 32'd0);
    check_val("foul_busy", 32'(busy), 32'd0);
    repeat (3) step(0, 1, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    check_val("foul_cleared", 32'(foul), 32'd0);
    check_val("restart_busy", 32'(busy), 32'd1);

    // No react: GO lasts MX*TD cycles and saturates.
    cnt = 0;
    while (!led_go && cnt < 300) begin step(0, 1, 0); cnt++; end
    cnt = 0;
    while (led_go && cnt < 300) begin step(0, 1, 0); cnt++; end
    check_val("go_len", cnt, 32'(MX * TD));
    check_val("sat_ms", 32'(result_ms), 32'(MX));
    check_val("sat_tmo", 32'(timeout), 32'd1);
    check_val("sat_valid", 32'(result_valid), 32'd1);

    // Start held through reset, react toggled in IDLE: nothing happens.
    repeat (2) step(1, 1, 0);
    step(0, 1, 0); step(0, 1, 1); step(0, 1, 0); step(0, 1, 1);
    check_val("idle_quiet", 32'(got_outs), 32'd0);

    // Reset in the middle of WAIT.
    step(0, 0, 0);
    step(0, 1, 0);
    repeat (10) step(0, 1, 0);
    check_val("mid_wait_busy", 32'(busy), 32'd1);
    step(1, 1, 0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_outs", 32'(got_outs), 32'd0);

    // Seven rounds at successive LFSR phases (first one confirms the reseed).
    mask = 8'd0;
    for (int k = 0; k < 7; k++) begin
      do step(0, 0, 0); while (m_t % 7 != k);
      step(0, 1, 0);
      mask = mask | (8'd1 << lfsr_sel);
      cnt = 0;
      while (!led_go && cnt < 300) begin step(0, 1, 0); cnt++; end
      check_val("sweep_wait", cnt - 1, 32'(wait_len()));
      repeat (2) step(0, 1, 0);
      step(0, 1, 1);
      check_val("sweep_done", 32'(result_valid), 32'd1);
      step(0, 0, 0);
    end
    check_val("sel_cover", 32'(mask), 32'h0FE);

    // Random button traffic with occasional resets.
    sb = 0; rb = 0;
    for (int n = 0; n < 6000; n++) begin
      if ($urandom_range(19) == 0) sb = ~sb;
      if ($urandom_range(59) == 0) rb = ~rb;
      rr = ($urandom_range(1499) == 0);
      step(rr, sb, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
